uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that converts a parallel byte into an asynchronous frame on a single line. The frame is a start bit, 8 data bits LSB first, an optional parity bit and one stop bit. It uses the same oversampled clock and `Prescale` convention as the UART receiver path, so a transmitter/receiver pair with equal `Prescale` interoperates directly. It sits between the system-side data source (e.g. a FIFO or register file) and the TX pin.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame.
- `CLK`  in  1  oversampled clock (Prescale cycles per bit).
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel byte to send.
- `DATA_VALID`  in  1  request; accepted only when `Busy`=0.
- `PAR_EN`  in  1  1 = insert parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `Prescale`  in  6  clock cycles per bit; 0 means 64.
- `TX_OUT`  out  1  serial line, idles high (registered).
- `Busy`  out  1  high from acceptance through the last stop-bit cycle (registered).

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **IDLE**
  - `TX_OUT`=1, `Busy`=0.
  - On `DATA_VALID`=1:
    - latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`;
    - compute the parity bit from the latched data;
    - go to START.
- **START**: `TX_OUT`=0 for one bit period, then go to DATA.
- **DATA**
  - Shift out latched bits 0..DATA_WIDTH-1, one per bit period.
  - A 3-bit (log2 DATA_WIDTH) bit index tracks progress.
  - After the last bit, go to PARITY if the latched `PAR_EN`=1, else to STOP.
- **PARITY**
  - `TX_OUT` = XOR of the data bits when `PAR_TYP`=0 (even).
  - `TX_OUT` = inverted XOR when `PAR_TYP`=1 (odd).
  - Lasts one bit period, then go to STOP.
- **STOP**: `TX_OUT`=1 for one bit period, then go to IDLE.
- **Bit-period counter**
  - 6-bit `edge_cnt` counts 0 .. P-1, where P = latched `Prescale`.
  - The state advances when `edge_cnt` = P-1; the counter then wraps to 0.
  - `Prescale`=0 gives a natural 6-bit wrap, i.e. 64 cycles per bit.
- **Ignored inputs**
  - `DATA_VALID` while `Busy`=1 is ignored; no queuing and no corruption of the frame in flight.
  - Changes on `P_DATA`, `PAR_EN`, `PAR_TYP` or `Prescale` while busy have no effect until the next acceptance.
- **Reset** (asynchronous, any state, including mid-frame):
  - FSM to IDLE; `TX_OUT`=1, `Busy`=0.
  - Counters and shift register cleared.
  - No partial frame resumes after reset is released.

## Timing
- **Acceptance**: `DATA_VALID` is sampled at rising edge k with the FSM in IDLE. From edge k, `TX_OUT`=0 and `Busy`=1 (one-cycle latency from request to start bit).
- **Bit period**: each bit is held exactly P cycles. Data bit i occupies cycles k+P(1+i) .. k+P(2+i)-1.
- **Frame length**: (10 + `PAR_EN`) × P cycles. `Busy` falls at edge k + (10+`PAR_EN`)·P, which is also when `TX_OUT` returns to its idle 1.
- **Back-to-back**: `DATA_VALID`=1 at the edge where the FSM enters IDLE is not accepted, because the FSM is still in STOP at that edge. It is accepted on the next edge, so there is at least one idle-high cycle between frames. This is the fixed behaviour and the bench checks it.
- **Glitch-free line**: `TX_OUT` and `Busy` come straight from flops, with no combinational path from inputs.

## Test plan
- **Reset values**: assert `RST`=0 → `TX_OUT`=1, `Busy`=0. Release reset and hold `DATA_VALID`=0 for 100 cycles → outputs unchanged.
- **No parity**: `P_DATA`=0xA5, `PAR_EN`=0, `Prescale`=8, one-cycle `DATA_VALID`.
  - Expect line sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - `Busy` high for exactly 80 cycles.
- **Parity**, `Prescale`=16, `PAR_EN`=1:
  - 0xA5 with `PAR_TYP`=0 → parity bit 0; with `PAR_TYP`=1 → parity bit 1.
  - 0x01 with `PAR_TYP`=0 → parity bit 1.
  - Each frame is 176 cycles.
- **Busy ignore**:
  - Pulse `DATA_VALID` with 0x3C mid-frame of 0xA5 → 0xA5 frame is unaltered and no second frame follows.
  - Holding `DATA_VALID`=1 continuously → consecutive frames separated by exactly 1 idle-high cycle.
- **Latching**: change `Prescale` 8→4 and `P_DATA` during the frame → current frame keeps 8-cycle bits; the next accepted frame uses 4.
- **Reset mid-frame**: assert `RST` during data bit 3 of 0x00 → `TX_OUT`=1 and `Busy`=0 asynchronously. After release, the line stays high until a new `DATA_VALID`. A round trip through the receiver with `Prescale`=8 recovers the transmitted bytes.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, start + DATA_WIDTH bits LSB first + optional parity + stop, Prescale clocks per bit (0 = 64)
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] sh;
  logic [BW-1:0] bit_idx;
  logic [5:0] edge_cnt, pre;
  logic par_en, par_bit, done, last, tx_nxt;
  assign done = edge_cnt == pre - 6'd1;
  assign last = bit_idx == BW'(DATA_WIDTH - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = DATA_VALID ? START : IDLE;
      START:   state_nxt = done ? DATA : START;
      DATA:    state_nxt = done && last ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  state_nxt = done ? STOP : PARITY;
      STOP:    state_nxt = done ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = state == START ? sh[0] : (done ? sh[1] : TX_OUT);
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      sh       <= '0;
      bit_idx  <= '0;
      edge_cnt <= '0;
      pre      <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      TX_OUT   <= tx_nxt;
      Busy     <= state_nxt != IDLE;
      edge_cnt <= state == IDLE || done ? 6'd0 : edge_cnt + 6'd1;
      if (state == IDLE && DATA_VALID) begin
        sh      <= P_DATA;
        pre     <= Prescale;
        par_en  <= PAR_EN;
        par_bit <= ^P_DATA ^ PAR_TYP;
        bit_idx <= '0;
      end else if (state == DATA && done) begin
        sh      <= sh >> 1;
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx
module tb_uart_tx;
  logic CLK = 1'b0, RST = 1'b1, DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic [5:0] Prescale = 6'd8;
  logic TX_OUT, Busy;
  int n_cmp = 0, n_err = 0;
  always #5 CLK = ~CLK;
  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .Prescale(Prescale),
    .TX_OUT(TX_OUT),
    .Busy(Busy)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      chk({tag, " tx"}, TX_OUT, 8'd1);
      chk({tag, " busy"}, Busy, 8'd0);
    end
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                       input logic [5:0] p, input logic [10:0] exp, input bit hold, input int poke);
    int pp;
    int nb;
    pp = p == 6'd0 ? 64 : int'(p);
    nb = pe ? 11 : 10;
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    Prescale = p;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) DATA_VALID = 1'b0;
    for (int c = 0; c < nb * pp; c++) begin
      if (c == poke) begin
        DATA_VALID = 1'b1;
        P_DATA = 8'h3C;
        Prescale = 6'd4;
        PAR_EN = ~pe;
        PAR_TYP = ~pt;
      end
      if (c == poke + 1) DATA_VALID = hold;
      chk($sformatf("%s bit%0d cyc%0d tx", tag, c / pp, c), TX_OUT, 8'(exp[c / pp]));
      chk($sformatf("%s cyc%0d busy", tag, c), Busy, 8'd1);
      @(posedge CLK);
      #1;
    end
    chk({tag, " end tx"}, TX_OUT, 8'd1);
    chk({tag, " end busy"}, Busy, 8'd0);
  endtask
  task automatic rx(input string tag, input logic [7:0] d);
    logic [7:0] r;
    int t;
    r = 8'h00;
    t = 0;
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Prescale = 6'd8;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    while (TX_OUT !== 1'b0 && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk({tag, " start edge"}, TX_OUT, 8'd0);
    repeat (4) @(posedge CLK);
    #1;
    chk({tag, " start mid"}, TX_OUT, 8'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge CLK);
      #1;
      r[i] = TX_OUT;
    end
    repeat (8) @(posedge CLK);
    #1;
    chk({tag, " stop mid"}, TX_OUT, 8'd1);
    chk({tag, " byte"}, r, d);
    repeat (5) @(posedge CLK);
    #1;
    chk({tag, " idle busy"}, Busy, 8'd0);
  endtask
  initial begin
    #2 RST = 1'b0;
    #1;
    chk("reset tx", TX_OUT, 8'd1);
    chk("reset busy", Busy, 8'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idle_for("post reset idle", 100);
    frame("np_a5", 8'hA5, 1'b0, 1'b0, 6'd8, {2'b11, 8'hA5, 1'b0}, 1'b0, -1);
    idle_for("gap1", 3);
    frame("par_a5_even", 8'hA5, 1'b1, 1'b0, 6'd16, {1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0, -1);
    frame("par_a5_odd", 8'hA5, 1'b1, 1'b1, 6'd16, {1'b1, 1'b1, 8'hA5, 1'b0}, 1'b0, -1);
    frame("par_01_even", 8'h01, 1'b1, 1'b0, 6'd16, {1'b1, 1'b1, 8'h01, 1'b0}, 1'b0, -1);
    idle_for("gap2", 3);
    frame("ign_a5", 8'hA5, 1'b0, 1'b0, 6'd8, {2'b11, 8'hA5, 1'b0}, 1'b0, 30);
    idle_for("ign no second frame", 40);
    frame("hold1", 8'hA5, 1'b0, 1'b0, 6'd8, {2'b11, 8'hA5, 1'b0}, 1'b1, -1);
    frame("hold2", 8'h3C, 1'b0, 1'b0, 6'd8, {2'b11, 8'h3C, 1'b0}, 1'b0, -1);
    idle_for("gap3", 3);
    frame("latch8", 8'hA5, 1'b0, 1'b0, 6'd8, {2'b11, 8'hA5, 1'b0}, 1'b0, 20);
    frame("latch4", 8'h3C, 1'b0, 1'b0, 6'd4, {2'b11, 8'h3C, 1'b0}, 1'b0, -1);
    frame("p64_ff", 8'hFF, 1'b0, 1'b0, 6'd0, {2'b11, 8'hFF, 1'b0}, 1'b0, -1);
    @(negedge CLK);
    P_DATA = 8'h00;
    PAR_EN = 1'b0;
    Prescale = 6'd8;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    repeat (35) @(posedge CLK);
    #1;
    chk("mid frame bit3 tx", TX_OUT, 8'd0);
    chk("mid frame busy", Busy, 8'd1);
    #2 RST = 1'b0;
    #1;
    chk("async reset tx", TX_OUT, 8'd1);
    chk("async reset busy", Busy, 8'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle_for("after mid reset", 100);
    rx("rx_5a", 8'h5A);
    rx("rx_c3", 8'hC3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
